// File: rtl/nn_output_reader.sv
// Reads NOUT signed fixed-point results from the output RAM after the network finishes,
// streams them over valid/ready with a threshold bit, and reports the argmax of the pass.
module nn_output_reader #(
  parameter int NOUT   = 1,
  parameter int AW     = 1,
  parameter int DW     = 8,
  parameter int THRESH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 trig_r,
  output logic [AW-1:0]        abus_r,
  input  logic signed [DW-1:0] dbus_r,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_data,
  output logic                 out_bit,
  output logic [AW-1:0]        out_index,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done,
  output logic [AW-1:0]        max_index,
  output logic signed [DW-1:0] max_value
);

  typedef enum logic [2:0] {IDLE, READ, CAPT, OUT, FIN} state_t;

  localparam logic [AW-1:0]        LAST_IDX = AW'(NOUT - 1);
  localparam logic signed [DW-1:0] THRESH_V = DW'(THRESH);

  state_t               state, state_nxt;
  logic [AW-1:0]        idx;
  logic [AW-1:0]        run_idx;
  logic signed [DW-1:0] run_max;
  logic                 hs;

  function automatic logic above_thresh(input logic signed [DW-1:0] v);
    return v >= THRESH_V;
  endfunction

  assign hs     = out_valid & out_ready;
  assign abus_r = idx;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    trig_r    = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = READ;
      READ: begin
        trig_r    = 1'b1;
        state_nxt = CAPT;
      end
      CAPT: state_nxt = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_valid & out_ready) state_nxt = out_last ? FIN : READ;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address counter, beat capture and running argmax
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      out_data  <= '0;
      out_bit   <= 1'b0;
      out_index <= '0;
      out_last  <= 1'b0;
      run_max   <= '0;
      run_idx   <= '0;
      max_index <= '0;
      max_value <= '0;
    end else begin
      case (state)
        IDLE: if (start) idx <= '0;
        CAPT: begin
          out_data  <= dbus_r;
          out_bit   <= above_thresh(dbus_r);
          out_index <= idx;
          out_last  <= (idx == LAST_IDX);
          // Strict compare so ties keep the lower index
          if (idx == '0 || dbus_r > run_max) begin
            run_max <= dbus_r;
            run_idx <= idx;
          end
        end
        OUT: begin
          if (hs && !out_last) idx <= idx + AW'(1);
          if (hs && out_last) begin
            max_index <= run_idx;
            max_value <= run_max;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_output_reader.sv
// Bench for nn_output_reader: one NOUT=1 instance and one NOUT=4 instance, each fed by a small RAM model.
module tb_nn_output_reader;

  typedef struct packed {
    logic signed [7:0] d;
    logic              b;
    logic [1:0]        i;
    logic              l;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // NOUT=1 instance
  logic              a_start = 1'b0, a_ready = 1'b1;
  logic              a_trig, a_valid, a_bit, a_last, a_busy, a_done;
  logic [0:0]        a_abus, a_index, a_maxi;
  logic signed [7:0] a_dbus = '0, a_data, a_maxv;
  logic signed [7:0] ram_a [2];

  // NOUT=4 instance
  logic              b_start = 1'b0, b_ready = 1'b1;
  logic              b_trig, b_valid, b_bit, b_last, b_busy, b_done;
  logic [1:0]        b_abus, b_index, b_maxi;
  logic signed [7:0] b_dbus = '0, b_data, b_maxv;
  logic signed [7:0] ram_b [4];

  beat_t q_a[$];
  beat_t q_b[$];

  nn_output_reader #(.NOUT(1), .AW(1), .DW(8), .THRESH(8)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .trig_r(a_trig), .abus_r(a_abus), .dbus_r(a_dbus),
    .out_valid(a_valid), .out_ready(a_ready), .out_data(a_data), .out_bit(a_bit),
    .out_index(a_index), .out_last(a_last), .busy(a_busy), .done(a_done),
    .max_index(a_maxi), .max_value(a_maxv));

  nn_output_reader #(.NOUT(4), .AW(2), .DW(8), .THRESH(8)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .trig_r(b_trig), .abus_r(b_abus), .dbus_r(b_dbus),
    .out_valid(b_valid), .out_ready(b_ready), .out_data(b_data), .out_bit(b_bit),
    .out_index(b_index), .out_last(b_last), .busy(b_busy), .done(b_done),
    .max_index(b_maxi), .max_value(b_maxv));

  // RAM model: data registered on the falling edge while the read strobe is up
  always @(negedge clk) begin
    if (a_trig) a_dbus <= ram_a[a_abus];
    if (b_trig) b_dbus <= ram_b[b_abus];
  end

  function automatic beat_t mk_beat(input logic signed [7:0] v, input int i, input int n);
    beat_t e;
    e.d = v;
    e.b = (v >= 8);
    e.i = 2'(i);
    e.l = (i == n - 1);
    return e;
  endfunction

  task automatic push_b_pass();
    for (int i = 0; i < 4; i++) q_b.push_back(mk_beat(ram_b[i], i, 4));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({a_trig, a_abus, a_valid, a_data, a_bit, a_index, a_last, a_busy, a_done, a_maxi, a_maxv} !== '0) begin
      n_fail++; $display("FAIL reset_a outputs obs=%h exp=0",
        {a_trig, a_abus, a_valid, a_data, a_bit, a_index, a_last, a_busy, a_done, a_maxi, a_maxv});
    end
    n_tests++;
    if ({b_trig, b_abus, b_valid, b_data, b_bit, b_index, b_last, b_busy, b_done, b_maxi, b_maxv} !== '0) begin
      n_fail++; $display("FAIL reset_b outputs obs=%h exp=0",
        {b_trig, b_abus, b_valid, b_data, b_bit, b_index, b_last, b_busy, b_done, b_maxi, b_maxv});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_pass();
    beat_t e, o;
    ram_a[0] = 8'sd16;
    a_ready  = 1'b1;
    q_a.push_back(mk_beat(ram_a[0], 0, 1));
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    n_tests++;
    if ({a_trig, a_abus} !== 2'b10) begin
      n_fail++; $display("FAIL single_read_c1 trig/abus obs=%b exp=10", {a_trig, a_abus});
    end
    @(negedge clk);
    n_tests++;
    if ({a_valid, a_trig, a_busy} !== 3'b001) begin
      n_fail++; $display("FAIL single_capt_c2 valid/trig/busy obs=%b exp=001", {a_valid, a_trig, a_busy});
    end
    @(negedge clk);
    o = {a_data, a_bit, 1'b0, a_index, a_last};
    e = q_a.pop_front();
    n_tests++;
    if (a_valid !== 1'b1 || o !== e) begin
      n_fail++; $display("FAIL single_beat_c3 valid=%b obs=%h exp=%h", a_valid, o, e);
    end
    @(negedge clk);
    n_tests++;
    if ({a_done, a_valid, a_maxi, a_maxv} !== {1'b1, 1'b0, 1'b0, 8'sd16}) begin
      n_fail++; $display("FAIL single_done_c4 done=%b valid=%b maxi=%0d maxv=%0d exp 1 0 0 16",
        a_done, a_valid, a_maxi, a_maxv);
    end
    @(negedge clk);
    n_tests++;
    if ({a_done, a_busy} !== 2'b00) begin
      n_fail++; $display("FAIL single_idle_c5 done/busy obs=%b exp=00", {a_done, a_busy});
    end
  endtask

  task automatic test_threshold();
    logic signed [7:0] vals [3];
    vals[0] = 8'sd7; vals[1] = 8'sd8; vals[2] = -8'sd128;
    a_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int got = 0, dones = 0, cyc = 0;
      ram_a[0] = vals[k];
      q_a.push_back(mk_beat(vals[k], 0, 1));
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      while ((got < 1 || dones == 0) && cyc < 20) begin
        if (a_valid && a_ready) begin
          beat_t o, e;
          o = {a_data, a_bit, 1'b0, a_index, a_last};
          e = q_a.pop_front();
          got++;
          n_tests++;
          if (o !== e) begin
            n_fail++; $display("FAIL thresh_beat v=%0d obs=%h exp=%h", vals[k], o, e);
          end
        end
        if (a_done) begin
          dones++;
          n_tests++;
          if (a_maxv !== vals[k]) begin
            n_fail++; $display("FAIL thresh_maxv obs=%0d exp=%0d", a_maxv, vals[k]);
          end
        end
        @(negedge clk);
        cyc++;
      end
      n_tests++;
      if (got != 1 || dones != 1) begin
        n_fail++; $display("FAIL thresh_count beats=%0d dones=%0d exp 1 1", got, dones);
      end
    end
  endtask

  task automatic test_multi();
    logic signed [7:0] mx;
    int mi, got = 0, dones = 0, cyc = 0, done_cyc = -1;
    ram_b[0] = 8'sd3; ram_b[1] = -8'sd20; ram_b[2] = 8'sd12; ram_b[3] = 8'sd12;
    mx = ram_b[0]; mi = 0;
    for (int i = 1; i < 4; i++) if (ram_b[i] > mx) begin mx = ram_b[i]; mi = i; end
    push_b_pass();
    b_ready = 1'b1;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    cyc = 1;
    while ((got < 4 || dones == 0) && cyc < 40) begin
      if (b_valid && b_ready) begin
        beat_t o, e;
        o = {b_data, b_bit, b_index, b_last};
        e = q_b.pop_front();
        got++;
        n_tests++;
        if (o !== e) begin
          n_fail++; $display("FAIL multi_beat%0d obs=%h exp=%h", got - 1, o, e);
        end
      end
      if (b_done) begin dones++; done_cyc = cyc; end
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (got != 4 || dones != 1 || done_cyc != 13) begin
      n_fail++; $display("FAIL multi_count beats=%0d dones=%0d done_cycle=%0d exp 4 1 13", got, dones, done_cyc);
    end
    n_tests++;
    if (b_maxi !== 2'(mi) || b_maxv !== mx) begin
      n_fail++; $display("FAIL multi_argmax obs=%0d/%0d exp=%0d/%0d", b_maxi, b_maxv, mi, mx);
    end
  endtask

  task automatic test_backpressure();
    int cyc = 0, got = 0, dones = 0;
    beat_t o, e;
    q_b.delete();
    push_b_pass();
    b_ready = 1'b0;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    while (!b_valid && cyc < 10) begin @(negedge clk); cyc++; end
    n_tests++;
    if (b_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_valid_rise obs=%b exp=1", b_valid);
    end
    for (int s = 0; s < 5; s++) begin
      n_tests++;
      if ({b_valid, b_trig} !== 2'b10 || b_data !== 8'sd3 || b_index !== 2'd0) begin
        n_fail++; $display("FAIL bp_stall%0d valid/trig=%b data=%0d idx=%0d exp 10 3 0",
          s, {b_valid, b_trig}, b_data, b_index);
      end
      if (s < 4) @(negedge clk);
    end
    b_ready = 1'b1;
    o = {b_data, b_bit, b_index, b_last};
    e = q_b.pop_front();
    n_tests++;
    if (o !== e) begin
      n_fail++; $display("FAIL bp_beat0 obs=%h exp=%h", o, e);
    end
    @(negedge clk);
    n_tests++;
    if ({b_trig, b_abus, b_valid} !== 4'b1010) begin
      n_fail++; $display("FAIL bp_next_read trig/abus/valid obs=%b exp=1010", {b_trig, b_abus, b_valid});
    end
    cyc = 0;
    while ((got < 3 || dones == 0) && cyc < 30) begin
      if (b_valid && b_ready) begin
        o = {b_data, b_bit, b_index, b_last};
        e = q_b.pop_front();
        got++;
        n_tests++;
        if (o !== e) begin
          n_fail++; $display("FAIL bp_beat%0d obs=%h exp=%h", got, o, e);
        end
      end
      if (b_done) dones++;
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (got != 3 || dones != 1) begin
      n_fail++; $display("FAIL bp_count beats=%0d dones=%0d exp 3 1", got, dones);
    end
  endtask

  task automatic test_start_ignored();
    int cyc = 1, got = 0, dones = 0, busy_seen = 0;
    q_b.delete();
    push_b_pass();
    b_ready = 1'b1;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    while ((got < 4 || dones == 0) && cyc < 40) begin
      if (b_valid && b_ready) begin
        beat_t o, e;
        o = {b_data, b_bit, b_index, b_last};
        if (q_b.size() == 0) e = '0;
        else e = q_b.pop_front();
        got++;
        n_tests++;
        if (o !== e) begin
          n_fail++; $display("FAIL ign_beat%0d obs=%h exp=%h", got - 1, o, e);
        end
      end
      if (b_done) dones++;
      b_start = (cyc == 2 || cyc == 5 || cyc == 9);
      @(negedge clk);
      cyc++;
    end
    b_start = 1'b0;
    repeat (6) begin
      if (b_busy || b_valid || b_done) busy_seen++;
      @(negedge clk);
    end
    n_tests++;
    if (got != 4 || dones != 1 || busy_seen != 0) begin
      n_fail++; $display("FAIL ign_no_restart beats=%0d dones=%0d busy_after=%0d exp 4 1 0", got, dones, busy_seen);
    end
  endtask

  task automatic test_reset_mid();
    int cyc = 0, got = 0, dones = 0;
    b_ready = 1'b0;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    while (!b_valid && cyc < 10) begin @(negedge clk); cyc++; end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({b_trig, b_abus, b_valid, b_data, b_bit, b_index, b_last, b_busy, b_done, b_maxi, b_maxv} !== '0) begin
      n_fail++; $display("FAIL rst_mid_outputs obs=%h exp=0",
        {b_trig, b_abus, b_valid, b_data, b_bit, b_index, b_last, b_busy, b_done, b_maxi, b_maxv});
    end
    @(negedge clk);
    rst = 1'b0;
    b_ready = 1'b1;
    repeat (4) begin
      if (b_done || b_busy) dones++;
      @(negedge clk);
    end
    n_tests++;
    if (dones != 0) begin
      n_fail++; $display("FAIL rst_mid_no_done activity=%0d exp=0", dones);
    end
    ram_b[0] = -8'sd5; ram_b[1] = 8'sd9; ram_b[2] = 8'sd127; ram_b[3] = -8'sd128;
    q_b.delete();
    push_b_pass();
    dones = 0; cyc = 0;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    while ((got < 4 || dones == 0) && cyc < 40) begin
      if (b_valid && b_ready) begin
        beat_t o, e;
        o = {b_data, b_bit, b_index, b_last};
        e = q_b.pop_front();
        got++;
        n_tests++;
        if (o !== e) begin
          n_fail++; $display("FAIL rst_clean_beat%0d obs=%h exp=%h", got - 1, o, e);
        end
      end
      if (b_done) dones++;
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (got != 4 || dones != 1 || b_maxi !== 2'd2 || b_maxv !== 8'sd127) begin
      n_fail++; $display("FAIL rst_clean_pass beats=%0d dones=%0d max=%0d/%0d exp 4 1 2/127",
        got, dones, b_maxi, b_maxv);
    end
  endtask

  initial begin
    ram_a[0] = '0; ram_a[1] = '0;
    for (int i = 0; i < 4; i++) ram_b[i] = '0;
    test_reset();
    test_single_pass();
    test_threshold();
    test_multi();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
